// File: rtl/cook_timer_controller_if.sv
`timescale 1ns/1ps
// Button pulses in, time/state/heater/beep out, between the debouncers and the
// display/heater logic of the microwave oven timer.
interface cook_timer_controller_if;
    logic       add_min;
    logic       add_10s;
    logic       start;
    logic       stop;
    logic       door_open;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic [2:0] state;
    logic       heater_on;
    logic       beep;
    logic       done_pulse;

    modport master (
        output add_min, add_10s, start, stop, door_open,
        input  minutes, seconds, state, heater_on, beep, done_pulse
    );

    modport slave (
        input  add_min, add_10s, start, stop, door_open,
        output minutes, seconds, state, heater_on, beep, done_pulse
    );
endinterface

// File: rtl/cook_timer_controller.sv
`timescale 1ns/1ps
// Microwave cook timer: button sequencing, mm:ss countdown driven by a one-second
// prescaler on the system clock, heater enable and end-of-cook beep.
module cook_timer_controller #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int BEEP_SEC = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    cook_timer_controller_if.slave bus
);
    localparam int PW = $clog2(CLK_HZ);
    localparam int BW = $clog2(BEEP_SEC + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SEC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE, CMD_STOP, CMD_DOOR, CMD_START, CMD_ADD_MIN, CMD_ADD_10S
    } cmd_t;

    state_t        state_q, state_d;
    logic [6:0]    minutes_q, minutes_d;
    logic [5:0]    seconds_q, seconds_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] beep_cnt_q, beep_cnt_d;
    logic          heater_q, beep_q, done_q, done_d;

    cmd_t          cmd;
    logic          tick, is_add, last_second;
    logic [PW-1:0] presc_next;
    logic [7:0]    sum_min;
    logic [6:0]    sum_sec;
    logic [6:0]    add_min_v, dec_min;
    logic [5:0]    add_sec_v, dec_sec;

    // Only the highest-priority button pending this cycle is acted on.
    // NOTE: every signal driven from always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cmd = CMD_NONE;
        if      (bus.stop)      cmd = CMD_STOP;
        else if (bus.door_open) cmd = CMD_DOOR;
        else if (bus.start)     cmd = CMD_START;
        else if (bus.add_min)   cmd = CMD_ADD_MIN;
        else if (bus.add_10s)   cmd = CMD_ADD_10S;
        is_add = (cmd == CMD_ADD_MIN) || (cmd == CMD_ADD_10S);

        tick       = (presc_q == PRESC_MAX);
        presc_next = tick ? '0 : presc_q + PW'(1);

        sum_min = {1'b0, minutes_q};
        sum_sec = {1'b0, seconds_q};
        if (cmd == CMD_ADD_MIN) begin
            sum_min = sum_min + 8'd1;
        end else begin
            sum_sec = sum_sec + 7'd10;
            if (sum_sec >= 7'd60) begin
                sum_sec = sum_sec - 7'd60;
                sum_min = sum_min + 8'd1;
            end
        end
        if (sum_min > 8'd99) begin
            add_min_v = 7'd99;
            add_sec_v = 6'd59;
        end else begin
            add_min_v = sum_min[6:0];
            add_sec_v = sum_sec[5:0];
        end

        last_second = (minutes_q == 7'd0) && (seconds_q == 6'd1);
        if (seconds_q == 6'd0) begin
            dec_min = minutes_q - 7'd1;
            dec_sec = 6'd59;
        end else begin
            dec_min = minutes_q;
            dec_sec = seconds_q - 6'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        minutes_d  = minutes_q;
        seconds_d  = seconds_q;
        presc_d    = presc_q;
        beep_cnt_d = beep_cnt_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (is_add) begin
                    minutes_d = add_min_v;
                    seconds_d = add_sec_v;
                    state_d   = S_SET;
                end
            end
            S_SET, S_PAUSE: begin
                if (cmd == CMD_STOP) begin
                    minutes_d = '0;
                    seconds_d = '0;
                    state_d   = S_IDLE;
                end else if (cmd == CMD_START) begin
                    state_d = S_COOK;
                    // A fresh cook starts a full second; a resume keeps the partial one.
                    if (state_q == S_SET) presc_d = '0;
                end else if (is_add) begin
                    minutes_d = add_min_v;
                    seconds_d = add_sec_v;
                end
            end
            S_COOK: begin
                if (cmd == CMD_STOP || cmd == CMD_DOOR || is_add) begin
                    // The cycle still counts, but a tick due now is deferred by one cycle.
                    presc_d = tick ? presc_q : presc_next;
                    if (is_add) begin
                        minutes_d = add_min_v;
                        seconds_d = add_sec_v;
                    end else begin
                        state_d = S_PAUSE;
                    end
                end else begin
                    presc_d = presc_next;
                    if (tick) begin
                        minutes_d = dec_min;
                        seconds_d = dec_sec;
                        if (last_second) begin
                            state_d    = S_DONE;
                            presc_d    = '0;
                            beep_cnt_d = '0;
                            done_d     = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                if (cmd == CMD_STOP) begin
                    state_d = S_IDLE;
                end else begin
                    presc_d = presc_next;
                    if (tick) begin
                        if (beep_cnt_q == BEEP_LAST) begin
                            state_d    = S_IDLE;
                            beep_cnt_d = '0;
                        end else begin
                            beep_cnt_d = beep_cnt_q + BW'(1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments; blocking is kept to always_comb.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            minutes_q  <= '0;
            seconds_q  <= '0;
            presc_q    <= '0;
            beep_cnt_q <= '0;
            heater_q   <= 1'b0;
            beep_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            minutes_q  <= minutes_d;
            seconds_q  <= seconds_d;
            presc_q    <= presc_d;
            beep_cnt_q <= beep_cnt_d;
            heater_q   <= (state_d == S_COOK);
            beep_q     <= (state_d == S_DONE);
            done_q     <= done_d;
        end
    end

    assign bus.minutes    = minutes_q;
    assign bus.seconds    = seconds_q;
    assign bus.state      = state_q;
    assign bus.heater_on  = heater_q;
    assign bus.beep       = beep_q;
    assign bus.done_pulse = done_q;
endmodule

// File: tb/tb_cook_timer_controller.sv
`timescale 1ns/1ps
// Directed bench for cook_timer_controller at CLK_HZ=10, BEEP_SEC=3; inputs and
// samples move on the falling edge, state changes on the rising edge.
module tb_cook_timer_controller;
    localparam int CLK_HZ   = 10;
    localparam int BEEP_SEC = 3;
    localparam int IDLE = 0, SET = 1, COOK = 2, PAUSE = 3, DONE = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    cook_timer_controller_if bus();

    cook_timer_controller #(.CLK_HZ(CLK_HZ), .BEEP_SEC(BEEP_SEC)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_time(input string tag, input int m, input int s);
        check({tag, ".min"}, int'(bus.minutes), m);
        check({tag, ".sec"}, int'(bus.seconds), s);
    endtask

    task automatic press_add_10s();
        bus.add_10s = 1'b1; step(1); bus.add_10s = 1'b0;
    endtask

    task automatic press_add_min();
        bus.add_min = 1'b1; step(1); bus.add_min = 1'b0;
    endtask

    task automatic press_start();
        bus.start = 1'b1; step(1); bus.start = 1'b0;
    endtask

    task automatic press_stop();
        bus.stop = 1'b1; step(1); bus.stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.add_min = 1'b0; bus.add_10s = 1'b0; bus.start = 1'b0;
        bus.stop = 1'b0;    bus.door_open = 1'b0;
        reset_n = 1'b0;
        step(2);
        check("rst.state", int'(bus.state), IDLE);
        check_time("rst", 0, 0);
        check("rst.heater", int'(bus.heater_on), 0);
        check("rst.beep", int'(bus.beep), 0);
        check("rst.done", int'(bus.done_pulse), 0);
        reset_n = 1'b1;
        step(1);

        // 0:10 uninterrupted cook through DONE and back to IDLE
        press_add_10s();
        check("c1.state_set", int'(bus.state), SET);
        check_time("c1.set", 0, 10);
        press_start();
        check("c1.state_cook", int'(bus.state), COOK);
        check("c1.heater_on", int'(bus.heater_on), 1);
        step(9);
        check_time("c1.before_tick", 0, 10);
        step(1);
        check_time("c1.first_tick", 0, 9);
        step(89);
        check("c1.still_cook", int'(bus.state), COOK);
        check_time("c1.last_sec", 0, 1);
        step(1);
        check("c1.state_done", int'(bus.state), DONE);
        check("c1.done_pulse", int'(bus.done_pulse), 1);
        check("c1.heater_off", int'(bus.heater_on), 0);
        check("c1.beep_on", int'(bus.beep), 1);
        check_time("c1.done", 0, 0);
        step(1);
        check("c1.done_pulse_fall", int'(bus.done_pulse), 0);
        step(28);
        check("c1.beep_held", int'(bus.beep), 1);
        check("c1.state_beeping", int'(bus.state), DONE);
        step(1);
        check("c1.beep_off", int'(bus.beep), 0);
        check("c1.state_idle", int'(bus.state), IDLE);

        // Add arithmetic and saturation
        for (int i = 0; i < 6; i++) press_add_10s();
        check_time("c2.six_10s", 1, 0);
        for (int i = 0; i < 98; i++) press_add_min();
        check_time("c2.98_min", 99, 0);
        press_add_min();
        check_time("c2.99th_min", 99, 59);
        press_add_min();
        check_time("c2.100th_min", 99, 59);
        press_stop();
        check("c2.stop_state", int'(bus.state), IDLE);
        check_time("c2.stop", 0, 0);

        // Door opened mid-cook keeps the partial second
        press_add_10s();
        press_add_10s();
        check_time("c3.set", 0, 20);
        press_start();
        step(54);
        bus.door_open = 1'b1;
        step(1);
        check("c3.pause_state", int'(bus.state), PAUSE);
        check("c3.pause_heater", int'(bus.heater_on), 0);
        check_time("c3.pause", 0, 15);
        press_start();
        check("c3.start_door_open", int'(bus.state), PAUSE);
        step(3);
        check_time("c3.held", 0, 15);
        bus.door_open = 1'b0;
        step(1);
        press_start();
        check("c3.resume_state", int'(bus.state), COOK);
        step(4);
        check_time("c3.before_resume_tick", 0, 15);
        step(1);
        check_time("c3.resume_tick", 0, 14);
        press_stop();
        check("c3.stop_pause", int'(bus.state), PAUSE);
        press_stop();
        check("c3.stop_idle", int'(bus.state), IDLE);
        check_time("c3.cleared", 0, 0);

        // Add coinciding with the final tick defers the tick by one cycle
        press_add_10s();
        press_start();
        step(99);
        check_time("c4.at_0_01", 0, 1);
        bus.add_10s = 1'b1;
        step(1);
        bus.add_10s = 1'b0;
        check_time("c4.add_on_tick", 0, 11);
        check("c4.state_after_add", int'(bus.state), COOK);
        step(1);
        check_time("c4.deferred_tick", 0, 10);
        check("c4.still_cook", int'(bus.state), COOK);
        step(9);
        check_time("c4.before_next", 0, 10);
        step(1);
        check_time("c4.next_tick", 0, 9);
        press_stop();
        press_stop();

        // stop and start together in SET
        press_add_10s();
        bus.stop = 1'b1;
        bus.start = 1'b1;
        step(1);
        bus.stop = 1'b0;
        bus.start = 1'b0;
        check("c5.stop_start_state", int'(bus.state), IDLE);
        check_time("c5.stop_start", 0, 0);

        // DONE: add ignored, stop returns to IDLE at once
        press_add_10s();
        press_start();
        step(100);
        check("c6.state_done", int'(bus.state), DONE);
        press_add_10s();
        check_time("c6.add_ignored", 0, 0);
        check("c6.add_state", int'(bus.state), DONE);
        step(13);
        check("c6.beep_before_stop", int'(bus.beep), 1);
        press_stop();
        check("c6.stop_state", int'(bus.state), IDLE);
        check("c6.stop_beep", int'(bus.beep), 0);

        // Asynchronous reset in the middle of a cook
        press_add_10s();
        press_start();
        step(15);
        check("c7.cook_state", int'(bus.state), COOK);
        check_time("c7.cook", 0, 9);
        #2;
        reset_n = 1'b0;
        #1;
        check("c7.rst_state", int'(bus.state), IDLE);
        check_time("c7.rst", 0, 0);
        check("c7.rst_heater", int'(bus.heater_on), 0);
        check("c7.rst_beep", int'(bus.beep), 0);
        check("c7.rst_done", int'(bus.done_pulse), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1);
        check("c7.after_rst_state", int'(bus.state), IDLE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
